rd_deserializer: RTL and testbench
==================================

Name: rd_deserializer

Overview:
- Receive-side counterpart of the RD serial data link.
- Accepts two parallel serial lanes carrying 12-bit words, MSB first, each followed by one odd-parity bit; lines idle high.
- Deserializes both lanes, checks parity, and writes each word pair plus error flags into an external buffer RAM.
- Counts words; flags completion after WORDS words; sits between the RD link front end (bit-strobe recovery and synchronizers) and the event buffer readout.

Parameters:
WORDS, 2048, words per lane per transfer
BITS, 12, data bits per word (parity bit is extra)
ADDR_W, 11, buffer address width; WORDS <= 2**ADDR_W
TIMEOUT, 64, idle-cycle limit mid-transfer (only with RD_TIMEOUT_EN)

Ports:
CLK  in  1  system clock; all logic on posedge
RST  in  1  asynchronous, active-high reset
ENABLE  in  1  level, synchronous to CLK; low forces IDLE
ACK  in  1  one-cycle pulse; releases DONE and re-arms
BIT_EN  in  1  one-cycle strobe: SERIAL_IN0/1 hold a valid bit this cycle
SERIAL_IN0  in  1  lane 0 serial data
SERIAL_IN1  in  1  lane 1 serial data
MEM_WE  out  1  buffer write strobe, one cycle per word
MEM_ADDR  out  ADDR_W  buffer write address = word index
MEM_DATA  out  2*BITS+2  {PERR1, PERR0, LANE1[11:0], LANE0[11:0]}
BUSY  out  1  high in ARMED or SHIFT
DONE  out  1  high in DONE state
PERR_CNT0  out  16  lane 0 parity error count, saturating
PERR_CNT1  out  16  lane 1 parity error count, saturating
TIMEOUT_ERR  out  1  sticky abort flag (tied 0 without RD_TIMEOUT_EN)

Behaviour:
- Reset: all outputs 0; state IDLE; bit count, word count and shift registers 0.
- States: IDLE, ARMED, SHIFT, DONE.
  - IDLE -> ARMED when ENABLE=1. Entering ARMED clears word count, bit count, PERR_CNT0/1 and TIMEOUT_ERR.
  - ARMED -> SHIFT on the first BIT_EN; that bit is bit 11 (MSB) of word 0.
  - SHIFT -> DONE on the clock edge that writes word WORDS-1.
  - DONE -> ARMED on ACK=1 with ENABLE=1.
  - Any state -> IDLE when ENABLE=0, overriding all else. A word in progress is discarded with no write; the counters keep their values.
- Bit counter 0..12, advanced only on BIT_EN:
  - Counts 0..11: shift the SERIAL_IN bit into the lane shift register (MSB first) and XOR it into the lane's running parity.
  - Count 12: parity bit. PERRn = ~(running_parity_n ^ SERIAL_INn), i.e. the 13 bits must hold an odd number of ones. Running parity and bit count then clear.
- Write latency: MEM_WE is high for exactly one cycle, on the edge after the parity-bit BIT_EN, with MEM_ADDR = word index and MEM_DATA as defined. MEM_ADDR/MEM_DATA hold until the next write.
- Word count increments with each MEM_WE.
- DONE rises on the same edge as the final MEM_WE.
- PERR_CNTn increments on a MEM_WE whose PERRn=1; saturates at 0xFFFF.
- BIT_EN while in IDLE or DONE is ignored, including trailing idle-high bits after the last word.
- BIT_EN on consecutive cycles is legal. The parity-bit cycle and the MEM_WE cycle may coincide with the next word's bit 11.
- ACK in any state other than DONE is ignored.
- ACK and ENABLE=0 in the same cycle: go to IDLE.

Optional Feature:
- RD_TIMEOUT_EN defined:
  - In SHIFT, a cycle counter counts consecutive cycles with BIT_EN=0 and clears on BIT_EN.
  - When it reaches TIMEOUT: set TIMEOUT_ERR, discard the partial word, go to DONE with no write.
  - ARMED never times out.
- RD_TIMEOUT_EN undefined:
  - No counter is built; TIMEOUT_ERR is constant 0.
  - SHIFT waits indefinitely.

Test Plan:
- Reset, ENABLE=1, send word 0 as lane0=0x000 parity 1 and lane1=0x000 parity 1, BIT_EN every cycle -> one MEM_WE, MEM_ADDR=0, MEM_DATA=0x0000000, PERR_CNT0/1=0.
- Full transfer with WORDS=2048, lane0 incrementing from 0 and lane1 decrementing from 0 (word 1 = 0x001/0xFFF), correct parity -> 2048 MEM_WE; last write MEM_ADDR=0x7FF with lane0=0x7FF and lane1=0x801; DONE=1 on that edge; 13 trailing high bits cause no write.
- Word 5 lane1 parity bit inverted -> MEM_DATA bit25=1 at MEM_ADDR=5, PERR_CNT1=1, PERR_CNT0=0; transfer still completes.
- BIT_EN pulsed every 3rd cycle -> identical RAM contents to the back-to-back case; each MEM_WE occurs exactly 1 cycle after the parity strobe.
- ENABLE dropped after bit 6 of word 10 -> IDLE, no write at address 10. Re-enable and resend -> word count restarts at 0 and PERR counters are cleared.
- RD_TIMEOUT_EN, TIMEOUT=64: BIT_EN stops mid-word 3 -> TIMEOUT_ERR=1 and DONE=1 after 64 idle cycles, last MEM_ADDR=2. ACK -> ARMED with TIMEOUT_ERR=0.

Source files
------------

// File: rtl/rd_deserializer_if.sv
// rtl/rd_deserializer_if.sv - RD link bit strobes in, event buffer RAM write port out
interface rd_deserializer_if #(
    parameter int BITS   = 12,
    parameter int ADDR_W = 11
);
    logic                BIT_EN;
    logic                SERIAL_IN0;
    logic                SERIAL_IN1;
    logic                MEM_WE;
    logic [ADDR_W-1:0]   MEM_ADDR;
    logic [2*BITS+1:0]   MEM_DATA;

    modport master (
        output BIT_EN, SERIAL_IN0, SERIAL_IN1,
        input  MEM_WE, MEM_ADDR, MEM_DATA
    );

    modport slave (
        input  BIT_EN, SERIAL_IN0, SERIAL_IN1,
        output MEM_WE, MEM_ADDR, MEM_DATA
    );
endinterface

// File: rtl/rd_deserializer.sv
// rtl/rd_deserializer.sv - two-lane RD link deserializer with odd-parity check and buffer RAM writer
// Optional idle timeout in SHIFT is built only when RD_TIMEOUT_EN is defined.
module rd_deserializer #(
    parameter int WORDS   = 2048,
    parameter int BITS    = 12,
    parameter int ADDR_W  = 11,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENABLE,
    input  logic              ACK,
    rd_deserializer_if.slave  link,
    output logic              BUSY,
    output logic              DONE,
    output logic [15:0]       PERR_CNT0,
    output logic [15:0]       PERR_CNT1,
    output logic              TIMEOUT_ERR
);
    localparam int CNT_W = $clog2(BITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SHIFT, S_DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [ADDR_W-1:0]   word_cnt;
    logic [BITS-1:0]     sh0;
    logic [BITS-1:0]     sh1;
    logic                par0;
    logic                par1;
    logic                arm;
    logic                parity_bit;
    logic                perr0;
    logic                perr1;
    logic                last_word;

    if (WORDS > (1 << ADDR_W) || TIMEOUT < 1) begin : g_bad_params
        $error("rd_deserializer: WORDS must fit ADDR_W and TIMEOUT must be positive");
    end

    assign arm        = ENABLE && ((state == S_IDLE) || (state == S_DONE && ACK));
    assign parity_bit = (bit_cnt == CNT_W'(BITS));
    // Odd parity: the 12 data bits plus the parity bit must carry an odd number of ones.
    assign perr0      = ~(par0 ^ link.SERIAL_IN0);
    assign perr1      = ~(par1 ^ link.SERIAL_IN1);
    assign last_word  = (word_cnt == ADDR_W'(WORDS - 1));

`ifdef RD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] idle_cnt;
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= S_IDLE;
            bit_cnt       <= '0;
            word_cnt      <= '0;
            sh0           <= '0;
            sh1           <= '0;
            par0          <= 1'b0;
            par1          <= 1'b0;
            link.MEM_WE   <= 1'b0;
            link.MEM_ADDR <= '0;
            link.MEM_DATA <= '0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            PERR_CNT0     <= '0;
            PERR_CNT1     <= '0;
`ifdef RD_TIMEOUT_EN
            idle_cnt      <= '0;
            TIMEOUT_ERR   <= 1'b0;
`endif
        end else begin
            link.MEM_WE <= 1'b0;
            if (!ENABLE) begin
                // Partial word is dropped; word and error counters are left for inspection.
                state   <= S_IDLE;
                BUSY    <= 1'b0;
                DONE    <= 1'b0;
                bit_cnt <= '0;
                par0    <= 1'b0;
                par1    <= 1'b0;
            end else if (arm) begin
                state     <= S_ARMED;
                BUSY      <= 1'b1;
                DONE      <= 1'b0;
                bit_cnt   <= '0;
                word_cnt  <= '0;
                sh0       <= '0;
                sh1       <= '0;
                par0      <= 1'b0;
                par1      <= 1'b0;
                PERR_CNT0 <= '0;
                PERR_CNT1 <= '0;
`ifdef RD_TIMEOUT_EN
                idle_cnt    <= '0;
                TIMEOUT_ERR <= 1'b0;
`endif
            end else if ((state == S_ARMED || state == S_SHIFT) && link.BIT_EN) begin
                state <= S_SHIFT;
`ifdef RD_TIMEOUT_EN
                idle_cnt <= '0;
`endif
                if (parity_bit) begin
                    link.MEM_WE   <= 1'b1;
                    link.MEM_ADDR <= word_cnt;
                    link.MEM_DATA <= {perr1, perr0, sh1, sh0};
                    word_cnt      <= word_cnt + 1'b1;
                    bit_cnt       <= '0;
                    par0          <= 1'b0;
                    par1          <= 1'b0;
                    if (perr0 && PERR_CNT0 != 16'hFFFF)
                        PERR_CNT0 <= PERR_CNT0 + 16'd1;
                    if (perr1 && PERR_CNT1 != 16'hFFFF)
                        PERR_CNT1 <= PERR_CNT1 + 16'd1;
                    if (last_word) begin
                        state <= S_DONE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end else begin
                    sh0     <= {sh0[BITS-2:0], link.SERIAL_IN0};
                    sh1     <= {sh1[BITS-2:0], link.SERIAL_IN1};
                    par0    <= par0 ^ link.SERIAL_IN0;
                    par1    <= par1 ^ link.SERIAL_IN1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
`ifdef RD_TIMEOUT_EN
            else if (state == S_SHIFT) begin
                if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
                    state       <= S_DONE;
                    BUSY        <= 1'b0;
                    DONE        <= 1'b1;
                    TIMEOUT_ERR <= 1'b1;
                    bit_cnt     <= '0;
                    par0        <= 1'b0;
                    par1        <= 1'b0;
                    idle_cnt    <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_rd_deserializer.sv
// tb/tb_rd_deserializer.sv - directed self-checking bench for rd_deserializer (RD_TIMEOUT_EN optional)
module tb_rd_deserializer;
    logic        CLK = 1'b0;
    logic        RST;
    logic        ENABLE;
    logic        ACK;
    logic        BUSY;
    logic        DONE;
    logic        TIMEOUT_ERR;
    logic [15:0] PERR_CNT0;
    logic [15:0] PERR_CNT1;

    rd_deserializer_if #(.BITS(12), .ADDR_W(11)) link ();

    rd_deserializer #(.WORDS(2048), .BITS(12), .ADDR_W(11), .TIMEOUT(64)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ENABLE      (ENABLE),
        .ACK         (ACK),
        .link        (link),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .PERR_CNT0   (PERR_CNT0),
        .PERR_CNT1   (PERR_CNT1),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    int          vectors = 0;
    int          miscompares = 0;
    int          wr_cnt = 0;
    int          lat_err = 0;
    int          base;
    int          errs;
    logic [25:0] ram [0:2047];
    logic [25:0] ref_ram [0:9];

    always @(negedge CLK) begin
        if (link.MEM_WE === 1'b1) begin
            ram[link.MEM_ADDR] = link.MEM_DATA;
            wr_cnt++;
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] lane1_of(input int i);
        return 12'((4096 - i) % 4096);
    endfunction

    function automatic logic [25:0] exp_word(input int i, input logic p0, input logic p1);
        return {p1, p0, lane1_of(i), 12'(i)};
    endfunction

    // Sends bit positions first..last-1 of a word (position 12 is the parity bit).
    task automatic send_word(input logic [11:0] d0, input logic [11:0] d1,
                             input logic bad0, input logic bad1,
                             input int gap, input int first, input int last);
        logic s0, s1;
        for (int b = first; b < last; b++) begin
            if (b < 12) begin
                s0 = d0[11-b];
                s1 = d1[11-b];
            end else begin
                s0 = ~(^d0) ^ bad0;
                s1 = ~(^d1) ^ bad1;
            end
            link.BIT_EN = 1'b1;
            link.SERIAL_IN0 = s0;
            link.SERIAL_IN1 = s1;
            tick();
            link.BIT_EN = 1'b0;
            link.SERIAL_IN0 = 1'b1;
            link.SERIAL_IN1 = 1'b1;
            if (b == 11 && link.MEM_WE !== 1'b0) lat_err++;
            if (b == 12 && link.MEM_WE !== 1'b1) lat_err++;
            for (int g = 0; g < gap; g++) begin
                tick();
                if (b == 12 && g == 0 && link.MEM_WE !== 1'b0) lat_err++;
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        ENABLE = 1'b0;
        ACK = 1'b0;
        link.BIT_EN = 1'b0;
        link.SERIAL_IN0 = 1'b1;
        link.SERIAL_IN1 = 1'b1;
        repeat (3) tick();
        chk("rst_we", {31'd0, link.MEM_WE}, 32'd0);
        chk("rst_addr", {21'd0, link.MEM_ADDR}, 32'd0);
        chk("rst_data", {6'd0, link.MEM_DATA}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_perr0", {16'd0, PERR_CNT0}, 32'd0);
        chk("rst_perr1", {16'd0, PERR_CNT1}, 32'd0);
        chk("rst_terr", {31'd0, TIMEOUT_ERR}, 32'd0);
        RST = 1'b0;
        tick();
        chk("idle_busy", {31'd0, BUSY}, 32'd0);

        ENABLE = 1'b1;
        tick();
        chk("armed_busy", {31'd0, BUSY}, 32'd1);

        // Word 0, then the rest of a full back-to-back transfer with word 5 lane1 parity flipped
        base = wr_cnt;
        send_word(12'h000, 12'h000, 1'b0, 1'b0, 0, 0, 13);
        chk("w0_we", {31'd0, link.MEM_WE}, 32'd1);
        chk("w0_addr", {21'd0, link.MEM_ADDR}, 32'd0);
        chk("w0_data", {6'd0, link.MEM_DATA}, 32'd0);
        chk("w0_perr0", {16'd0, PERR_CNT0}, 32'd0);
        chk("w0_perr1", {16'd0, PERR_CNT1}, 32'd0);
        for (int i = 1; i < 2048; i++)
            send_word(12'(i), lane1_of(i), 1'b0, (i == 5), 0, 0, 13);
        chk("last_we", {31'd0, link.MEM_WE}, 32'd1);
        chk("last_done", {31'd0, DONE}, 32'd1);
        chk("last_addr", {21'd0, link.MEM_ADDR}, 32'h7FF);
        chk("last_data", {6'd0, link.MEM_DATA}, 32'h008017FF);
        tick();
        chk("full_wr_cnt", wr_cnt - base, 32'd2048);
        errs = 0;
        for (int i = 0; i < 2048; i++)
            if (ram[i] !== exp_word(i, 1'b0, (i == 5))) errs++;
        chk("full_ram", errs, 32'd0);
        chk("w5_bit25", {31'd0, ram[5][25]}, 32'd1);
        chk("full_perr0", {16'd0, PERR_CNT0}, 32'd0);
        chk("full_perr1", {16'd0, PERR_CNT1}, 32'd1);
        chk("full_busy", {31'd0, BUSY}, 32'd0);
        chk("lat_b2b", lat_err, 32'd0);

        // Trailing idle-high strobes in DONE
        base = wr_cnt;
        for (int b = 0; b < 13; b++) begin
            link.BIT_EN = 1'b1;
            tick();
        end
        link.BIT_EN = 1'b0;
        tick();
        chk("trail_no_wr", wr_cnt - base, 32'd0);
        chk("trail_done", {31'd0, DONE}, 32'd1);

        // Re-arm and resend words 0..9 with BIT_EN every third cycle
        for (int i = 0; i < 10; i++) begin
            ref_ram[i] = ram[i];
            ram[i] = '0;
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("ack_busy", {31'd0, BUSY}, 32'd1);
        chk("ack_done", {31'd0, DONE}, 32'd0);
        chk("ack_perr1_clr", {16'd0, PERR_CNT1}, 32'd0);
        base = wr_cnt;
        lat_err = 0;
        for (int i = 0; i < 10; i++)
            send_word(12'(i), lane1_of(i), 1'b0, (i == 5), 2, 0, 13);
        tick();
        chk("slow_lat", lat_err, 32'd0);
        chk("slow_wr_cnt", wr_cnt - base, 32'd10);
        errs = 0;
        for (int i = 0; i < 10; i++)
            if (ram[i] !== ref_ram[i]) errs++;
        chk("slow_ram", errs, 32'd0);
        chk("slow_perr1", {16'd0, PERR_CNT1}, 32'd1);

        // Drop ENABLE after six bits of word 10; strobes in IDLE must not write
        send_word(12'd10, lane1_of(10), 1'b0, 1'b0, 0, 0, 6);
        ENABLE = 1'b0;
        tick();
        chk("drop_busy", {31'd0, BUSY}, 32'd0);
        for (int b = 0; b < 13; b++) begin
            link.BIT_EN = 1'b1;
            link.SERIAL_IN0 = b[0];
            tick();
        end
        link.BIT_EN = 1'b0;
        link.SERIAL_IN0 = 1'b1;
        tick();
        chk("drop_no_wr", wr_cnt - base, 32'd10);
        chk("drop_perr1_kept", {16'd0, PERR_CNT1}, 32'd1);
        chk("drop_done", {31'd0, DONE}, 32'd0);

        ENABLE = 1'b1;
        tick();
        chk("reen_busy", {31'd0, BUSY}, 32'd1);
        chk("reen_perr1_clr", {16'd0, PERR_CNT1}, 32'd0);
        send_word(12'h123, 12'h456, 1'b0, 1'b0, 0, 0, 13);
        chk("reen_addr", {21'd0, link.MEM_ADDR}, 32'd0);
        chk("reen_data", {6'd0, link.MEM_DATA}, 32'h00456123);

        // Stall mid-word 3
        send_word(12'd1, 12'hFFF, 1'b0, 1'b0, 0, 0, 13);
        send_word(12'd2, 12'hFFE, 1'b0, 1'b0, 0, 0, 13);
        send_word(12'd3, 12'hFFD, 1'b0, 1'b0, 0, 0, 5);
`ifdef RD_TIMEOUT_EN
        repeat (63) tick();
        chk("to_before_done", {31'd0, DONE}, 32'd0);
        chk("to_before_terr", {31'd0, TIMEOUT_ERR}, 32'd0);
        tick();
        chk("to_done", {31'd0, DONE}, 32'd1);
        chk("to_terr", {31'd0, TIMEOUT_ERR}, 32'd1);
        chk("to_busy", {31'd0, BUSY}, 32'd0);
        chk("to_last_addr", {21'd0, link.MEM_ADDR}, 32'd2);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("to_ack_busy", {31'd0, BUSY}, 32'd1);
        chk("to_ack_terr", {31'd0, TIMEOUT_ERR}, 32'd0);
        chk("to_ack_done", {31'd0, DONE}, 32'd0);
`else
        repeat (200) tick();
        chk("stall_terr", {31'd0, TIMEOUT_ERR}, 32'd0);
        chk("stall_busy", {31'd0, BUSY}, 32'd1);
        chk("stall_done", {31'd0, DONE}, 32'd0);
        send_word(12'd3, 12'hFFD, 1'b0, 1'b0, 0, 5, 13);
        chk("stall_we", {31'd0, link.MEM_WE}, 32'd1);
        chk("stall_addr", {21'd0, link.MEM_ADDR}, 32'd3);
        chk("stall_data", {6'd0, link.MEM_DATA}, 32'h00FFD003);
`endif

        ENABLE = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
